// File: rtl/bcd_timekeeper_if.sv
// Load/alarm control bus and BCD time/alarm outputs of the timekeeper.
// The clock and reset stay plain ports on the module.
interface bcd_timekeeper_if;
  logic        load_en;
  logic        load_target;
  logic [1:0]  load_field;
  logic [7:0]  load_data;
  logic        alarm_en;
  logic        alarm_clear;
  logic [31:0] time_out;
  logic [31:0] alarm_out;
  logic        tick;
  logic        load_err;
  logic        alarm_sound;

  modport master (
    output load_en, load_target, load_field, load_data, alarm_en, alarm_clear,
    input  time_out, alarm_out, tick, load_err, alarm_sound
  );

  modport slave (
    input  load_en, load_target, load_field, load_data, alarm_en, alarm_clear,
    output time_out, alarm_out, tick, load_err, alarm_sound
  );
endinterface

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day clock (HH:MM:SS.CC) with field-wise loading and a ringing
// alarm that emits a 2 Hz square wave for up to 60 s.
module bcd_timekeeper #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  bcd_timekeeper_if.slave   bus
);

  localparam int DIV         = CLK_HZ / TICK_HZ;
  localparam int PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RING_TICKS  = 6000;
  localparam int SOUND_TICKS = 25;

  typedef enum logic {IDLE, RINGING} state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   time_q, time_d;
  logic [31:0]   alarm_q, alarm_d;
  logic          load_err_q, load_err_d;
  state_t        state_q;
  logic [12:0]   ring_cnt_q;
  logic [4:0]    snd_cnt_q;
  logic          sound_q;

  logic tick_w, fld_ok, time_ld, alarm_ld, inc, match;

  // Two-digit BCD increment; bit 8 is the carry out when the field wraps at maxv.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 9'h000 | 9'h100;
    else if (v[3:0] == 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [31:0] time_inc(input logic [31:0] t);
    logic [8:0] cc, ss, mm, hh;
    cc = bcd_inc(t[7:0], 8'h99);
    ss = cc[8] ? bcd_inc(t[15:8],  8'h59) : {1'b0, t[15:8]};
    mm = ss[8] ? bcd_inc(t[23:16], 8'h59) : {1'b0, t[23:16]};
    hh = mm[8] ? bcd_inc(t[31:24], 8'h23) : {1'b0, t[31:24]};
    return {hh[7:0], mm[7:0], ss[7:0], cc[7:0]};
  endfunction

  // With both nibbles <= 9, BCD values order the same as their binary encoding.
  function automatic logic field_valid(input logic [1:0] f, input logic [7:0] v);
    logic [7:0] maxv;
    case (f)
      2'd0:    maxv = 8'h23;
      2'd1:    maxv = 8'h59;
      2'd2:    maxv = 8'h59;
      default: maxv = 8'h99;
    endcase
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= maxv);
  endfunction

  function automatic logic [31:0] set_field(input logic [31:0] t, input logic [1:0] f,
                                            input logic [7:0] v);
    logic [31:0] r;
    r = t;
    case (f)
      2'd0:    r[31:24] = v;
      2'd1:    r[23:16] = v;
      2'd2:    r[15:8]  = v;
      default: r[7:0]   = v;
    endcase
    return r;
  endfunction

  always_comb begin
    tick_w     = (presc_q == PW'(DIV - 1));
    fld_ok     = field_valid(bus.load_field, bus.load_data);
    time_ld    = bus.load_en && fld_ok && !bus.load_target;
    alarm_ld   = bus.load_en && fld_ok && bus.load_target;
    load_err_d = bus.load_en && !fld_ok;
    presc_d    = (time_ld || tick_w) ? '0 : presc_q + PW'(1);
    time_d     = time_q;
    inc        = 1'b0;
    // A valid time load overrides the tick increment of the same cycle.
    if (time_ld) begin
      time_d = set_field(time_q, bus.load_field, bus.load_data);
    end else if (tick_w) begin
      time_d = time_inc(time_q);
      inc    = 1'b1;
    end
    alarm_d = alarm_ld ? set_field(alarm_q, bus.load_field, bus.load_data) : alarm_q;
    match   = inc && bus.alarm_en && (time_d[31:8] == alarm_q[31:8]) && (time_d[7:0] == 8'h00);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      time_q     <= '0;
      alarm_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      time_q     <= time_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snd_cnt_q  <= '0;
      sound_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match && !bus.alarm_clear) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
            snd_cnt_q  <= '0;
            sound_q    <= 1'b1;
          end
        end
        RINGING: begin
          if (bus.alarm_clear || !bus.alarm_en ||
              (tick_w && ring_cnt_q == 13'(RING_TICKS - 1))) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snd_cnt_q  <= '0;
            sound_q    <= 1'b0;
          end else if (tick_w) begin
            ring_cnt_q <= ring_cnt_q + 13'd1;
            if (snd_cnt_q == 5'(SOUND_TICKS - 1)) begin
              snd_cnt_q <= '0;
              sound_q   <= ~sound_q;
            end else begin
              snd_cnt_q <= snd_cnt_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sound_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_out    = time_q;
  assign bus.alarm_out   = alarm_q;
  assign bus.tick        = tick_w;
  assign bus.load_err    = load_err_q;
  assign bus.alarm_sound = sound_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed and random checks of bcd_timekeeper against a time-of-day model
// that counts hundredths since midnight as a plain integer.
module tb_bcd_timekeeper;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DAY     = 8640000;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;

  bcd_timekeeper_if bus();

  bcd_timekeeper #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  int m_time;
  int m_alarm[4];
  int m_presc;
  bit m_err;
  bit m_ring;
  int m_rticks;
  bit m_sound;

  function automatic int lim(input int f);
    case (f)
      0:       return 23;
      1, 2:    return 59;
      default: return 99;
    endcase
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] time_bcd(input int t);
    return {bcd2(t / 360000), bcd2((t / 6000) % 60), bcd2((t / 100) % 60), bcd2(t % 100)};
  endfunction

  function automatic logic [31:0] alarm_bcd();
    return {bcd2(m_alarm[0]), bcd2(m_alarm[1]), bcd2(m_alarm[2]), bcd2(m_alarm[3])};
  endfunction

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0;
    foreach (m_alarm[i]) m_alarm[i] = 0;
    m_presc  = 0;
    m_err    = 1'b0;
    m_ring   = 1'b0;
    m_rticks = 0;
    m_sound  = 1'b0;
  endtask

  // Applies one rising edge worth of behaviour to the model, using current inputs.
  task automatic model_edge();
    int hi, lo, v, f, h, mi, s, c;
    bit ok, tick_now, inc, match;
    f  = int'(bus.load_field);
    hi = int'(bus.load_data[7:4]);
    lo = int'(bus.load_data[3:0]);
    v  = hi * 10 + lo;
    ok = (hi <= 9) && (lo <= 9) && (v <= lim(f));
    tick_now = (m_presc == DIV - 1);
    m_err = bus.load_en && !ok;
    inc = 1'b0;
    if (bus.load_en && ok && !bus.load_target) begin
      h  = m_time / 360000;
      mi = (m_time / 6000) % 60;
      s  = (m_time / 100) % 60;
      c  = m_time % 100;
      case (f)
        0:       h  = v;
        1:       mi = v;
        2:       s  = v;
        default: c  = v;
      endcase
      m_time  = ((h * 60 + mi) * 60 + s) * 100 + c;
      m_presc = 0;
    end else if (tick_now) begin
      m_time  = (m_time + 1) % DAY;
      inc     = 1'b1;
      m_presc = 0;
    end else begin
      m_presc++;
    end
    match = inc && bus.alarm_en && (m_time % 100 == 0) &&
            (m_time / 100 == (m_alarm[0] * 60 + m_alarm[1]) * 60 + m_alarm[2]);
    if (bus.load_en && ok && bus.load_target) m_alarm[f] = v;
    if (!m_ring) begin
      if (match && !bus.alarm_clear) begin
        m_ring   = 1'b1;
        m_rticks = 0;
      end
    end else if (bus.alarm_clear || !bus.alarm_en || (tick_now && m_rticks == 5999)) begin
      m_ring = 1'b0;
    end else if (tick_now) begin
      m_rticks++;
    end
    m_sound = m_ring && ((m_rticks / 25) % 2 == 0);
  endtask

  task automatic cycle();
    if (rst_n) model_edge();
    @(posedge CLOCK_50);
    #1;
    check("cycle", {bus.time_out, bus.alarm_out, bus.tick, bus.load_err, bus.alarm_sound},
          {time_bcd(m_time), alarm_bcd(), 1'(m_presc == DIV - 1), m_err, m_sound});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input logic tgt, input logic [1:0] fld, input logic [7:0] d);
    bus.load_en     = 1'b1;
    bus.load_target = tgt;
    bus.load_field  = fld;
    bus.load_data   = d;
    cycle();
    bus.load_en = 1'b0;
  endtask

  task automatic wait_sound(input string tag);
    int n;
    n = 0;
    while (!bus.alarm_sound && n < 400) begin
      cycle();
      n++;
    end
    check(tag, bus.alarm_sound, 1'b1);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (!bus.tick && n < 20) begin
      cycle();
      n++;
    end
    check(tag, bus.tick, 1'b1);
  endtask

  initial begin
    int ticks, n;
    bus.load_en     = 1'b0;
    bus.load_target = 1'b0;
    bus.load_field  = 2'd0;
    bus.load_data   = 8'h00;
    bus.alarm_en    = 1'b0;
    bus.alarm_clear = 1'b0;
    model_reset();

    run(3);
    check("rst_time", bus.time_out, 32'h0);
    check("rst_alarm", bus.alarm_out, 32'h0);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_err", bus.load_err, 1'b0);
    check("rst_sound", bus.alarm_sound, 1'b0);

    // Free run from reset: 1000 cycles = 100 ticks = one second.
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (bus.tick) ticks++;
    end
    check("tick_count", ticks, 100);
    check("time_1s", bus.time_out, 32'h00000100);

    load(1'b0, 2'd0, 8'h23);
    load(1'b0, 2'd1, 8'h59);
    load(1'b0, 2'd2, 8'h59);
    load(1'b0, 2'd3, 8'h99);
    check("pre_wrap", bus.time_out, 32'h23595999);
    run(10);
    check("midnight_wrap", bus.time_out, 32'h00000000);

    load(1'b0, 2'd1, 8'h6A);
    check("err_mm6A", bus.load_err, 1'b1);
    check("keep_mm6A", bus.time_out, 32'h00000000);
    load(1'b0, 2'd0, 8'h24);
    check("err_hh24", bus.load_err, 1'b1);
    check("keep_hh24", bus.time_out, 32'h00000000);
    load(1'b1, 2'd2, 8'hA0);
    check("err_alarm_nib", bus.load_err, 1'b1);
    check("keep_alarm", bus.alarm_out, 32'h00000000);
    cycle();
    check("err_one_cycle", bus.load_err, 1'b0);

    // Load on the tick cycle wins and restarts the prescaler.
    load(1'b0, 2'd0, 8'h10);
    load(1'b0, 2'd1, 8'h20);
    load(1'b0, 2'd2, 8'h30);
    load(1'b0, 2'd3, 8'h40);
    wait_tick("tick_before_load");
    load(1'b0, 2'd1, 8'h12);
    check("load_on_tick", bus.time_out, 32'h10123040);
    n = 0;
    while (!bus.tick && n < 20) begin
      cycle();
      n++;
    end
    check("tick_gap_after_load", n + 1, 10);

    load(1'b1, 2'd0, 8'h00);
    load(1'b1, 2'd1, 8'h00);
    load(1'b1, 2'd2, 8'h01);
    load(1'b1, 2'd3, 8'h00);
    check("alarm_reg", bus.alarm_out, 32'h00000100);
    bus.alarm_en = 1'b1;
    load(1'b0, 2'd0, 8'h00);
    load(1'b0, 2'd1, 8'h00);
    load(1'b0, 2'd2, 8'h00);
    load(1'b0, 2'd3, 8'h00);
    ticks = 0;
    n = 0;
    while (!bus.alarm_sound && n < 2000) begin
      cycle();
      if (bus.tick) ticks++;
      n++;
    end
    check("ring_after_ticks", ticks, 100);
    check("ring_sound_high", bus.alarm_sound, 1'b1);
    n = 0;
    while (bus.alarm_sound && n < 400) begin
      cycle();
      n++;
    end
    check("sound_half_period", n, 250);
    ticks = n;
    n = 0;
    while (m_ring && n < 70000) begin
      cycle();
      n++;
    end
    check("ring_timeout_cycles", ticks + n, 60000);
    run(300);
    check("silent_after_timeout", bus.alarm_sound, 1'b0);

    load(1'b0, 2'd1, 8'h00);
    load(1'b0, 2'd2, 8'h00);
    load(1'b0, 2'd3, 8'h90);
    wait_sound("ring_for_clear");
    run(7);
    bus.alarm_clear = 1'b1;
    cycle();
    bus.alarm_clear = 1'b0;
    check("clear_silences", bus.alarm_sound, 1'b0);
    run(3);
    load(1'b0, 2'd3, 8'h00);
    check("load_equals_alarm", bus.time_out, 32'h00000100);
    run(300);
    check("no_ring_from_load", bus.alarm_sound, 1'b0);

    load(1'b0, 2'd2, 8'h00);
    load(1'b0, 2'd3, 8'h99);
    wait_tick("tick_for_clear_race");
    bus.alarm_clear = 1'b1;
    cycle();
    bus.alarm_clear = 1'b0;
    check("clear_beats_match_time", bus.time_out, 32'h00000100);
    run(30);
    check("clear_beats_match", bus.alarm_sound, 1'b0);

    load(1'b0, 2'd2, 8'h00);
    load(1'b0, 2'd3, 8'h99);
    wait_sound("ring_for_en_drop");
    bus.alarm_en = 1'b0;
    cycle();
    check("en_drop_silences", bus.alarm_sound, 1'b0);
    bus.alarm_en = 1'b1;

    load(1'b0, 2'd2, 8'h00);
    load(1'b0, 2'd3, 8'h99);
    wait_sound("ring_for_reset");
    rst_n = 1'b0;
    #1;
    check("async_reset_sound", bus.alarm_sound, 1'b0);
    check("async_reset_time", bus.time_out, 32'h0);
    model_reset();
    run(2);
    rst_n = 1'b1;

    // Random loads and controls around an alarm two seconds ahead.
    load(1'b1, 2'd2, 8'h02);
    load(1'b0, 2'd3, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      bus.load_en     = ($urandom_range(0, 15) == 0);
      bus.load_target = 1'($urandom_range(0, 1));
      bus.load_field  = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0)
        bus.load_data = 8'($urandom_range(0, 255));
      else
        bus.load_data = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      bus.alarm_clear = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 255) == 0) bus.alarm_en = ~bus.alarm_en;
      cycle();
    end
    bus.load_en     = 1'b0;
    bus.alarm_clear = 1'b0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, hundredths-of-second tick rate; DIV = CLK_HZ/TICK_HZ.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_en  input  1  one-cycle write strobe.
REQ-006 SHALL have port load_target  input  1  0 = time register, 1 = alarm register.
REQ-007 SHALL have port load_field  input  2  field select: 0 = hours, 1 = minutes, 2 = seconds, 3 = hundredths.
REQ-008 SHALL have port load_data  input  8  two-digit packed BCD value.
REQ-009 SHALL have port alarm_en  input  1  level; alarm armed while high.
REQ-010 SHALL have port alarm_clear  input  1  one-cycle acknowledge; stops ringing.
REQ-011 SHALL have port time_out  output  32  packed BCD {HH[31:24], MM[23:16], SS[15:8], CC[7:0]}.
REQ-012 SHALL have port alarm_out  output  32  packed BCD alarm register, same layout.
REQ-013 SHALL have port tick  output  1  one-cycle pulse per hundredth.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse on rejected load.
REQ-015 SHALL have port alarm_sound  output  1  registered 2 Hz square wave while ringing, else 0.

Function
REQ-016 SHALL run a prescaler 0..DIV-1; tick = 1 for exactly the cycle the prescaler is at DIV-1, then the prescaler wraps to 0.
REQ-017 SHALL, on each tick, advance the time register in the same cycle: CC 00..99, carry to SS 00..59, carry to MM 00..59, carry to HH 00..23, 23:59:59.99 -> 00:00:00.00.
REQ-018 SHALL use BCD arithmetic per digit; the low digit 9 -> 0 with carry; no binary intermediate values are visible on time_out.
REQ-019 SHALL accept a load when load_en = 1 only if both nibbles are <= 9 and the value is within field range (HH <= 23, MM/SS <= 59, CC <= 99); time_out/alarm_out updates on the next cycle.
REQ-020 SHALL, on an invalid load, leave all registers unchanged and pulse load_err the following cycle.
REQ-021 SHALL, on a valid time load, reset the prescaler to 0 and suppress any tick increment in that cycle; the load value wins over the increment.
REQ-022 SHALL leave time counting and the prescaler unaffected by alarm loads.
REQ-023 SHALL implement alarm FSM states IDLE and RINGING.
REQ-024 SHALL move IDLE -> RINGING on the cycle after an increment makes time_out[31:8] == alarm_out[31:8], with CC == 00 and alarm_en = 1.
REQ-025 SHALL never trigger the alarm from a load, even when the loaded time matches.
REQ-026 SHALL move RINGING -> IDLE on alarm_clear = 1, on alarm_en = 0, or after 6000 ticks in RINGING (60 s timeout), whichever comes first.
REQ-027 SHALL, in RINGING, toggle alarm_sound every 25 ticks, starting high on entry; alarm_sound SHALL be 0 in the cycle after exit.
REQ-028 SHALL give alarm_clear priority when alarm_clear and a new match occur in the same cycle: the FSM stays or returns to IDLE.
REQ-029 SHALL count in RINGING using a ring-tick counter that resets to 0 on every entry to RINGING.

Reset
REQ-030 SHALL, while rst_n = 0, force time_out = 0, alarm_out = 0, prescaler = 0, tick = 0, load_err = 0, alarm_sound = 0, FSM = IDLE, and ring counter = 0.
REQ-031 SHALL resume counting from 00:00:00.00 with the first tick DIV cycles after rst_n deasserts; reset mid-ring silences the alarm immediately.

Verification (CLK_HZ = 1000, TICK_HZ = 100, DIV = 10)
REQ-032 SHALL cover: release reset, run 1000 cycles -> tick pulses every 10 cycles and time_out = 32'h00000100.
REQ-033 SHALL cover: load HH = 8'h23, MM = 8'h59, SS = 8'h59, CC = 8'h99, then one tick -> time_out = 32'h00000000.
REQ-034 SHALL cover: load MM = 8'h6A, then HH = 8'h24 -> load_err pulses each time and time_out is unchanged.
REQ-035 SHALL cover: alarm 00:00:01.00, alarm_en = 1, run from 0 -> RINGING after 100 ticks, alarm_sound toggles every 250 cycles, returns to 0 after 6000 ticks.
REQ-036 SHALL cover: during RINGING pulse alarm_clear -> alarm_sound = 0 the next cycle; then load a time equal to the alarm -> no ring.
REQ-037 SHALL cover: assert a time load on the same cycle as a tick -> loaded value appears, no increment, next tick 10 cycles later.
